// File: rtl/fifo_stream_reader.sv
// Read-side companion to the 16x8 push/pop FIFO: pops words ahead of demand and
// presents them as a full-throughput valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_pop,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_idx, rd_idx;
  logic [1:0]            occ, occ_nxt;
  logic                  inflight;
  logic                  xfer;

  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[rd_idx];
  assign xfer    = m_valid && m_ready;
  // Occupancy once this edge's capture and transfer land; also the pop headroom test.
  assign occ_nxt = occ + {1'b0, inflight} - {1'b0, xfer};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = (occ_nxt != 2'd0 || fifo_pop) ? DRAIN : IDLE;
      DRAIN: begin
        if (en)                                  state_nxt = RUN;
        else if (occ_nxt == 2'd0 && !fifo_pop)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    fifo_pop = !rst && (state == RUN) && en && !fifo_empty && (occ_nxt < 2'd2);
    busy     = (state != IDLE);
  end

  // Skid buffer, indices and delivered-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_idx   <= 1'b0;
      rd_idx   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      if (inflight) begin
        mem[wr_idx] <= fifo_data;
        wr_idx      <= ~wr_idx;
      end
      if (xfer) begin
        rd_idx   <= ~rd_idx;
        rd_count <= rd_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
      occ      <= occ_nxt;
      inflight <= fifo_pop;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO environment plus a queue-level
// reference of buffered words, checked every cycle under directed and random traffic.
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_pop;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        busy;
  logic [15:0] rd_count;

  fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];     // FIFO environment contents
  logic [7:0] mq[$];         // words held by the reader, oldest first
  logic [7:0] delivered[$];
  bit         m_infl = 0;
  logic [7:0] infl_word = '0;
  int         mode = 0;      // 0 idle, 1 run, 2 drain
  int         exp_count = 0;
  bit         just_rst = 1;
  bit         pop_seen = 0;
  int         pop_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // One clock: check outputs at negedge, advance the reference, then service the FIFO.
  task automatic tick();
    bit exp_valid, xfer, exp_pop;
    int occ_out;
    @(negedge clk);
    exp_valid = (mq.size() > 0);
    chk("m_valid", m_valid, exp_valid);
    if (exp_valid)     chk("m_data", m_data, mq[0]);
    else if (just_rst) chk("m_data_rst", m_data, 0);
    xfer    = exp_valid && m_ready;
    occ_out = mq.size() + int'(m_infl) - int'(xfer);
    exp_pop = !rst && mode == 1 && en && fifo_q.size() > 0 && occ_out < 2;
    chk("fifo_pop", fifo_pop, exp_pop);
    chk("busy", busy, mode != 0);
    chk("rd_count", rd_count, exp_count);
    pop_seen = fifo_pop;
    if (pop_seen) pop_cnt++;
    just_rst = 0;
    if (rst) begin
      mq.delete();
      m_infl    = 0;
      mode      = 0;
      exp_count = 0;
      just_rst  = 1;
    end else begin
      if (xfer) begin
        delivered.push_back(mq.pop_front());
        exp_count = (exp_count + 1) & 32'hFFFF;
      end
      if (m_infl) mq.push_back(infl_word);
      m_infl = exp_pop;
      if (exp_pop) infl_word = fifo_q[0];
      case (mode)
        0: if (en) mode = 1;
        1: if (!en) mode = (mq.size() > 0 || exp_pop) ? 2 : 0;
        2: if (en) mode = 1; else if (mq.size() == 0 && !m_infl) mode = 0;
        default: mode = 0;
      endcase
    end
    @(posedge clk);
    #1;
    if (pop_seen && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_until(input string tag, input int n, input int bound);
    int i = 0;
    while (delivered.size() < n && i < bound) begin
      tick();
      i++;
    end
    chk(tag, delivered.size(), n);
  endtask

  task automatic clear_log();
    delivered.delete();
    pop_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_data = '0; fifo_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();  // reset state

    // 1: three words at full rate
    push(8'h11); push(8'h22); push(8'h33);
    en = 1'b1; m_ready = 1'b1;
    run_until("t1_done", 3, 20);
    chk("t1_pops", pop_cnt, 3);
    chk("t1_d0", delivered[0], 8'h11);
    chk("t1_d2", delivered[2], 8'h33);
    chk("t1_cnt", rd_count, 3);
    en = 1'b0;
    repeat (3) tick();
    chk("t1_idle", busy, 0);

    // 2: sixteen words with m_ready toggling
    clear_log();
    for (int i = 0; i < 16; i++) push(8'(i));
    en = 1'b1;
    for (int i = 0; i < 80 && delivered.size() < 16; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    chk("t2_done", delivered.size(), 16);
    for (int i = 0; i < 16 && i < delivered.size(); i++) chk("t2_order", delivered[i], i);
    chk("t2_pops", pop_cnt, 16);

    // 3: backpressure fills the skid buffer with exactly two pops
    clear_log();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    repeat (10) tick();
    chk("t3_pops", pop_cnt, 2);
    chk("t3_hold", m_data, 8'h40);
    m_ready = 1'b1;
    run_until("t3_done", 5, 20);
    chk("t3_pops_all", pop_cnt, 5);
    for (int i = 0; i < 5 && i < delivered.size(); i++) chk("t3_order", delivered[i], 8'h40 + i);

    // 4: en falls right after a pop
    clear_log();
    push(8'hA5);
    for (int i = 0; i < 20 && !pop_seen; i++) tick();
    en = 1'b0;
    chk("t4_drain", busy, 1);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("t4_idle", busy, 0);
    chk("t4_pops", pop_cnt, 1);
    chk("t4_word", delivered.size() == 1 ? delivered[0] : 8'h00, 8'hA5);

    // 5: enabled on an empty FIFO, then one word arrives
    clear_log();
    en = 1'b1;
    repeat (5) tick();
    chk("t5_busy", busy, 1);
    chk("t5_pops", pop_cnt, 0);
    push(8'h7E);
    run_until("t5_done", 1, 10);
    chk("t5_word", delivered.size() == 1 ? delivered[0] : 8'h00, 8'h7E);

    // 6: reset with a full skid buffer and rd_count=9
    do_reset();
    for (int i = 0; i < 12; i++) push(8'h90 + 8'(i));
    en = 1'b1; m_ready = 1'b1;
    run_until("t6_nine", 9, 30);
    m_ready = 1'b0;
    repeat (4) tick();
    chk("t6_cnt9", rd_count, 9);
    chk("t6_full", m_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", m_valid, 0);
    chk("t6_cnt0", rd_count, 0);
    chk("t6_busy", busy, 0);
    en = 1'b0;
    tick();
    fifo_q.delete();
    fifo_empty = 1'b1;

    // Random traffic with occasional reset, including resets with a pop in flight
    clear_log();
    for (int i = 0; i < 2000; i++) begin
      en      = ($urandom % 8) != 0;
      m_ready = ($urandom % 3) != 0;
      rst     = ($urandom % 150) == 0;
      if (fifo_q.size() < 16 && ($urandom % 2) == 1) push(8'($urandom));
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
